miriscv_mdu: RTL and testbench

Iterative RV32M multiply/divide unit and the multi-cycle companion to the single-cycle integer ALU. Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on XLEN-bit operands. Uses a req/ready/done handshake so the core's decode stage can stall on busy. One shift-add or restoring-divide step per clock.

---
 rtl/miriscv_mdu_pkg.sv | 31 +++
 rtl/miriscv_mdu_divstep.sv | 24 ++
 rtl/miriscv_mdu.sv | 148 ++++++++++++++
 tb/tb_miriscv_mdu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 opcodes, FSM states
// and operand-signedness helpers.
package miriscv_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic a_is_signed(input logic [2:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/miriscv_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module miriscv_mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            next_bit,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted  = {rem[XLEN-1:0], next_bit};
    diff     = shifted - {1'b0, divisor};
    // A set top bit means the true shifted value exceeds any XLEN-bit divisor.
    q_bit    = rem[XLEN] | (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/miriscv_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// clock on operand magnitudes, with sign fix-up before the result is published.
module miriscv_mdu
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state, state_next;
  mdu_op_e           op;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [XLEN-1:0]   result;

  logic              sign_a, sign_b, div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_next;
  logic              q_bit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Operand conditioning and special-case detection at accept
  always_comb begin
    sign_a   = a_is_signed(op_i) & a_i[XLEN-1];
    sign_b   = b_is_signed(op_i) & b_i[XLEN-1];
    mag_a    = sign_a ? -a_i : a_i;
    mag_b    = sign_b ? -b_i : b_i;
    div_zero = op_i[2] && (b_i == '0);
    div_ovf  = (op_i == MDU_DIV || op_i == MDU_REM) && (a_i == INT_MIN) && (&b_i);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_i[1] ? a_i : '1;
    else          special_res = op_i[1] ? '0 : a_i;
  end

  // Multiply step: conditionally add multiplicand into the high half, shift right
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, prod[XLEN-1:1]};
  end

  miriscv_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (rem),
    .divisor  (opnd),
    .next_bit (prod[XLEN-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_fix  = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op)
      MDU_MUL:                         fix_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_res = quo_fix;
      default:                         fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= MDU_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (req_i) state_next = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: begin
        if (kill_i)                     state_next = MDU_IDLE;
        else if (cnt == CNT_W'(1))      state_next = MDU_FIX;
      end
      MDU_FIX:  state_next = kill_i ? MDU_IDLE : MDU_DONE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == MDU_IDLE);
    busy_o  = (state != MDU_IDLE);
    done_o  = (state == MDU_DONE);
  end

  assign result_o = result;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      op     <= MDU_MUL;
      opnd   <= '0;
      prod   <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (req_i) begin
          op  <= mdu_op_e'(op_i);
          neg <= (op_i[2] && op_i[1]) ? sign_a : (sign_a ^ sign_b);
          cnt <= CNT_W'(XLEN);
          rem <= '0;
          // Divide keeps the divisor in opnd and shifts the dividend out of prod
          if (op_i[2]) begin
            opnd <= mag_b;
            prod <= {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd <= mag_a;
            prod <= {{XLEN{1'b0}}, mag_b};
          end
          if (special) result <= special_res;
        end
        MDU_CALC: if (!kill_i) begin
          cnt <= cnt - CNT_W'(1);
          if (op[2]) begin
            rem  <= rem_next;
            prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], q_bit};
          end else begin
            prod <= mul_next;
          end
        end
        MDU_FIX: if (!kill_i) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_mdu.sv
// Scoreboard bench for miriscv_mdu: directed RV32M cases, corner cases and random
// operations compared against a wide-arithmetic reference model.
module tb_miriscv_mdu;
  import miriscv_mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic            req = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            ready, busy, done;
  logic [XLEN-1:0] result;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic rdy_seen = 1'b0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          acc_cyc;
    int          lat;
  } txn_t;
  txn_t sb[$];

  miriscv_mdu #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .arstn_i  (arstn),
    .req_i    (req),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .kill_i   (kill),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] xs, ys, xu, yu, p;
    logic [31:0] r;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    xu = {32'b0, x};
    yu = {32'b0, y};
    r  = '0;
    case (o)
      3'd0: begin p = xs * ys; r = p[31:0];  end
      3'd1: begin p = xs * ys; r = p[63:32]; end
      3'd2: begin p = xs * yu; r = p[63:32]; end
      3'd3: begin p = xu * yu; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else r = $signed(x) / $signed(y);
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x,
                                    input logic [31:0] y);
    return (o[2] && y == 0) ||
           ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Present one request, wait for acceptance, then scramble the inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    txn_t t;
    int n = 0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    req = 1'b1; op = o; a = x; b = y;
    if (push) begin
      t.op = o; t.a = x; t.b = y; t.exp = ref_model(o, x, y);
      t.acc_cyc = cyc;
      t.lat = is_special(o, x, y) ? 1 : XLEN + 2;
      sb.push_back(t);
      last_exp = t.exp;
    end
    @(posedge clk); #1;
    req = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pop the scoreboard whenever the unit signals done
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (arstn && sb.size() > 0 && cyc > sb[0].acc_cyc && (ready || !busy)) rdy_seen = 1'b1;
    if (arstn && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        t = sb.pop_front();
        chk($sformatf("result op=%0d a=%h b=%h", t.op, t.a, t.b), result, t.exp);
        chk($sformatf("latency op=%0d", t.op), 32'(cyc - t.acc_cyc), 32'(t.lat));
        chk("busy_while_in_flight", 32'(rdy_seen), 32'd0);
      end
      rdy_seen = 1'b0;
    end
  end

  logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'd0};
  logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd0, 32'd9};

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    #12;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk); arstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
    wait_drain();

    // Requests while busy are ignored
    issue(3'd5, 32'd1000, 32'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    end
    @(negedge clk); req = 1'b0;
    wait_drain();

    // Kill in IDLE does not block acceptance; kill in DONE has no effect
    kill = 1'b1;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    kill = 1'b0;
    wait_drain();
    issue(3'd5, 32'd77, 32'd0, 1'b1);
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    wait_drain();

    // Kill ten cycles into CALC
    issue(3'd4, 32'd12345, 32'd67, 1'b0);
    repeat (9) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill_ready", 32'(ready), 32'd1);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_result_kept", result, last_exp);
    repeat (40) @(negedge clk);

    // Async reset mid-CALC
    issue(3'd1, 32'h7FFF_0001, 32'h0003_0005, 1'b0);
    repeat (5) @(posedge clk);
    #3; arstn = 1'b0; #1;
    chk("midreset_ready", 32'(ready), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk); arstn = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel < 4) rb = 32'($urandom_range(1, 20)) ^ (sel == 3 ? 32'hFFFF_FFFF : 32'h0);
      issue(ro, ra, rb, 1'b1);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
